// File: rtl/aer_stream_pkg.sv
// Shared constants for the AER spike streamer: FSM encoding and event address prefixes.
package aer_stream_pkg;
  localparam int unsigned PIX_W = 11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_SETUP = 3'd3;
  localparam logic [2:0] ST_REQ   = 3'd4;
  localparam logic [2:0] ST_REL   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [1:0] PIX_PREFIX  = 2'b00;
  localparam logic [1:0] TICK_PREFIX = 2'b01;
endpackage

// File: rtl/spike_frame_buf.sv
// Simple dual-port byte RAM holding the spike raster; registered 1-cycle read.
module spike_frame_buf #(
  parameter int unsigned DEPTH = 784,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/aer_spike_streamer.sv
// Replays a buffered T x N spike raster as 4-phase AER events, one tick event per time step.
module aer_spike_streamer
  import aer_stream_pkg::*;
#(
  parameter int unsigned N         = 784,
  parameter int unsigned T         = 8,
  parameter logic [9:0]  TICK_CODE = 10'h0FF,
  parameter int unsigned AER_W     = 12,
  localparam int unsigned DEPTH  = T * N / 8,
  localparam int unsigned BUF_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [BUF_AW-1:0] WR_ADDR,
  input  logic [7:0]        WR_DATA,
  input  logic              START,
  output logic [AER_W-1:0]  AEROUT_ADDR,
  output logic              AEROUT_REQ,
  input  logic              AEROUT_ACK,
  input  logic              SCHED_FULL,
  output logic              BUSY,
  output logic              SAMPLE_DONE,
  output logic [15:0]       SPK_CNT
);
  localparam int unsigned T_W = (T > 1) ? $clog2(T) : 1;

  logic [2:0]        state_q, state_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [BUF_AW-1:0] rd_addr_q, rd_addr_d;
  logic              tick_q, tick_d;
  logic [AER_W-1:0]  addr_q, addr_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              rd_en;
  logic [7:0]        rd_data;

  logic [PIX_W-1:0]  pix_inc;
  logic              byte_end, step_end, cur_bit;
  logic [AER_W-1:0]  pix_addr, tick_addr;

  spike_frame_buf #(.DEPTH(DEPTH), .AW(BUF_AW)) u_buf (
    .clk   (CLK),
    .we    (WR_EN && !busy_q),
    .waddr (WR_ADDR),
    .wdata (WR_DATA),
    .re    (rd_en),
    .raddr (rd_addr_q),
    .rdata (rd_data)
  );

  // The RAM output holds the fetched byte for the whole scan; pix[2:0] walks it MSB first.
  assign pix_inc   = pix_q + PIX_W'(1);
  assign byte_end  = &pix_q[2:0];
  assign step_end  = (pix_inc == PIX_W'(N));
  assign cur_bit   = rd_data[3'd7 - pix_q[2:0]];
  assign pix_addr  = AER_W'({PIX_PREFIX, pix_q[9:0]});
  assign tick_addr = AER_W'({TICK_PREFIX, TICK_CODE});

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    pix_d     = pix_q;
    rd_addr_d = rd_addr_q;
    tick_d    = tick_q;
    addr_d    = addr_q;
    req_d     = req_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    rd_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          t_d       = '0;
          pix_d     = '0;
          cnt_d     = '0;
          rd_addr_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_en     = 1'b1;
        rd_addr_d = rd_addr_q + BUF_AW'(1);
        state_d   = ST_SCAN;
      end
      ST_SCAN: begin
        // A new address is only latched once any outstanding ACK has dropped.
        if (cur_bit) begin
          if (!AEROUT_ACK) begin
            addr_d  = pix_addr;
            tick_d  = 1'b0;
            state_d = ST_SETUP;
          end
        end else if (byte_end && step_end) begin
          if (!AEROUT_ACK) begin
            pix_d   = pix_inc;
            addr_d  = tick_addr;
            tick_d  = 1'b1;
            state_d = ST_SETUP;
          end
        end else begin
          pix_d = pix_inc;
          if (byte_end) state_d = ST_FETCH;
        end
      end
      ST_SETUP: begin
        if (!SCHED_FULL && !AEROUT_ACK) begin
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (AEROUT_ACK) begin
          req_d   = 1'b0;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        if (!AEROUT_ACK) begin
          if (tick_q) begin
            pix_d = '0;
            t_d   = t_q + T_W'(1);
            if (t_q == T_W'(T - 1)) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_FETCH;
            end
          end else begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
            pix_d = pix_inc;
            if (!byte_end) begin
              state_d = ST_SCAN;
            end else if (step_end) begin
              addr_d  = tick_addr;
              tick_d  = 1'b1;
              state_d = ST_SETUP;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      pix_q     <= '0;
      rd_addr_q <= '0;
      tick_q    <= 1'b0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      pix_q     <= pix_d;
      rd_addr_q <= rd_addr_d;
      tick_q    <= tick_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign AEROUT_ADDR = addr_q;
  assign AEROUT_REQ  = req_q;
  assign BUSY        = busy_q;
  assign SAMPLE_DONE = done_q;
  assign SPK_CNT     = cnt_q;
endmodule

// File: tb/tb_aer_spike_streamer.sv
// Self-checking bench: raster replay against a loop-based event model plus handshake monitor.
module tb_aer_spike_streamer;
  localparam int unsigned N = 16, T = 2, NB = N / 8, DEPTH = T * NB, AW = 2;
  localparam logic [11:0] TICK_ADDR = 12'h4FF;

  logic          CLK = 1'b0;
  logic          RST, WR_EN, START, AEROUT_REQ, AEROUT_ACK, SCHED_FULL, BUSY, SAMPLE_DONE;
  logic [AW-1:0] WR_ADDR;
  logic [7:0]    WR_DATA;
  logic [11:0]   AEROUT_ADDR;
  logic [15:0]   SPK_CNT;

  int n_cmp = 0, n_bad = 0;
  int sd_cnt = 0, viol = 0, ack_dly = 20, exp_cnt = 0;
  bit sf_hold = 1'b0, sf_rand = 1'b0;
  logic [7:0]  ref_mem [DEPTH];
  logic [11:0] got_q[$], exp_q[$];

  aer_spike_streamer #(.N(N), .T(T), .TICK_CODE(10'h0FF), .AER_W(12)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .START(START), .AEROUT_ADDR(AEROUT_ADDR), .AEROUT_REQ(AEROUT_REQ),
    .AEROUT_ACK(AEROUT_ACK), .SCHED_FULL(SCHED_FULL), .BUSY(BUSY),
    .SAMPLE_DONE(SAMPLE_DONE), .SPK_CNT(SPK_CNT)
  );

  always #5 CLK = ~CLK;

  // Core-side ACK responder with a programmable delay on both edges.
  initial begin
    AEROUT_ACK = 1'b0;
    forever begin
      @(posedge AEROUT_REQ);
      #(ack_dly); @(posedge CLK); #1 AEROUT_ACK = 1'b1;
      wait (!AEROUT_REQ);
      #(ack_dly); @(posedge CLK); #1 AEROUT_ACK = 1'b0;
    end
  end

  initial begin
    SCHED_FULL = 1'b0;
    forever begin
      @(posedge CLK); #1;
      SCHED_FULL = sf_hold | (sf_rand & ($urandom_range(3) == 0));
    end
  end

  // Event capture and 4-phase rule monitor.
  initial begin
    logic p_req, p_ack, p_rst;
    logic [11:0] p_addr;
    p_req = 1'b0; p_ack = 1'b0; p_rst = 1'b1; p_addr = '0;
    forever begin
      @(negedge CLK);
      if (!RST && !p_rst) begin
        if (AEROUT_REQ && !p_req) begin
          got_q.push_back(AEROUT_ADDR);
          if (p_ack) viol++;
        end
        if ((p_req || p_ack) && (AEROUT_ADDR !== p_addr)) viol++;
      end
      if (SAMPLE_DONE) sd_cnt++;
      p_req = AEROUT_REQ; p_ack = AEROUT_ACK; p_rst = RST; p_addr = AEROUT_ADDR;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input int a, input logic [7:0] d, input bit upd);
    @(negedge CLK); WR_EN = 1'b1; WR_ADDR = AW'(a); WR_DATA = d;
    @(negedge CLK); WR_EN = 1'b0;
    if (upd) ref_mem[a] = d;
  endtask

  task automatic pulse_start();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
  endtask

  // Expected events straight from the raster: set pixels in order, then a tick per step.
  task automatic build_exp();
    logic [7:0] b;
    exp_q.delete(); exp_cnt = 0;
    for (int t = 0; t < T; t++) begin
      for (int p = 0; p < N; p++) begin
        b = ref_mem[t * NB + p / 8];
        if (b[7 - (p % 8)]) begin
          exp_q.push_back({2'b00, 10'(p)});
          exp_cnt++;
        end
      end
      exp_q.push_back(TICK_ADDR);
    end
  endtask

  task automatic wait_done(input string tag);
    int s;
    s = sd_cnt;
    for (int i = 0; i < 5000 && sd_cnt == s; i++) @(negedge CLK);
    repeat (3) @(negedge CLK);
    check({tag, " done_pulses"}, 32'(sd_cnt - s), 32'd1);
  endtask

  task automatic compare(input string tag);
    check({tag, " n_events"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s ev%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, " spk_cnt"}, 32'(SPK_CNT), 32'(exp_cnt));
    check({tag, " busy"}, 32'(BUSY), 32'd0);
    check({tag, " viol"}, 32'(viol), 32'd0);
  endtask

  task automatic run_sample(input string tag);
    got_q.delete(); build_exp();
    pulse_start();
    wait_done(tag);
    compare(tag);
  endtask

  task automatic load_random();
    for (int a = 0; a < DEPTH; a++) wr_byte(a, 8'($urandom) & 8'($urandom), 1'b1);
  endtask

  initial begin
    int cnt;
    logic [11:0] a0;
    bit stable;
    RST = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0; START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst addr", 32'(AEROUT_ADDR), 32'd0);
    check("rst req", 32'(AEROUT_REQ), 32'd0);
    check("rst busy", 32'(BUSY), 32'd0);
    check("rst done", 32'(SAMPLE_DONE), 32'd0);
    check("rst spk", 32'(SPK_CNT), 32'd0);
    @(negedge CLK); RST = 1'b0;

    for (int a = 0; a < DEPTH; a++) wr_byte(a, 8'h00, 1'b1);
    wr_byte(0, 8'h80, 1'b1);
    run_sample("single");

    wr_byte(0, 8'h00, 1'b1);
    wr_byte(1, 8'h01, 1'b1);
    run_sample("bitorder");

    // All-zero raster: first REQ is the tick, after 9 cycles per byte plus START and SETUP.
    wr_byte(1, 8'h00, 1'b1);
    got_q.delete(); build_exp();
    @(negedge CLK); START = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      cnt++;
      if (cnt == 1) START = 1'b0;
      if (AEROUT_REQ) break;
    end
    check("zero_step latency", 32'(cnt), 32'(9 * NB + 2));
    check("zero_step addr", 32'(AEROUT_ADDR), 32'(TICK_ADDR));
    wait_done("zero_step");
    compare("zero_step");

    ack_dly = 100;
    for (int a = 0; a < DEPTH; a++) wr_byte(a, 8'hFF, 1'b1);
    run_sample("all_ones");

    ack_dly = 20;
    load_random();
    wr_byte(0, 8'hA5, 1'b1);
    got_q.delete(); build_exp();
    sf_hold = 1'b1;
    pulse_start();
    repeat (5) @(negedge CLK);
    a0 = AEROUT_ADDR; stable = 1'b1;
    repeat (50) begin
      @(negedge CLK);
      if (AEROUT_REQ || AEROUT_ADDR !== a0) stable = 1'b0;
    end
    check("sched_full stable", 32'(stable), 32'd1);
    check("sched_full addr", 32'(a0), 32'(exp_q[0]));
    @(negedge CLK); sf_hold = 1'b0;
    @(posedge CLK); #1;
    check("sched_full req_low", 32'(AEROUT_REQ), 32'd0);
    @(posedge CLK); #1;
    check("sched_full req_rise", 32'(AEROUT_REQ), 32'd1);
    wait_done("sched_full");
    compare("sched_full");

    ack_dly = 30;
    load_random();
    got_q.delete(); build_exp();
    pulse_start();
    repeat (2) @(negedge CLK);
    check("busy_flag", 32'(BUSY), 32'd1);
    pulse_start();
    wr_byte(0, ~ref_mem[0], 1'b0);
    wr_byte(3, ~ref_mem[3], 1'b0);
    wait_done("busy_ign");
    compare("busy_ign");
    run_sample("replay");

    // Reset with REQ and ACK both high, then restart while the orphaned ACK is still up.
    ack_dly = 100;
    wr_byte(0, 8'hC3, 1'b1);
    got_q.delete();
    pulse_start();
    for (int i = 0; i < 200 && !(AEROUT_REQ && AEROUT_ACK); i++) @(negedge CLK);
    check("rst_mid req_ack", 32'({AEROUT_REQ, AEROUT_ACK}), 32'd3);
    RST = 1'b1;
    #1;
    check("rst_mid req", 32'(AEROUT_REQ), 32'd0);
    check("rst_mid busy", 32'(BUSY), 32'd0);
    @(negedge CLK); RST = 1'b0;
    got_q.delete(); build_exp();
    pulse_start();
    check("rst_mid spk0", 32'(SPK_CNT), 32'd0);
    wait_done("rst_mid");
    compare("rst_mid");

    sf_rand = 1'b1;
    for (int r = 0; r < 5; r++) begin
      ack_dly = int'($urandom_range(40));
      load_random();
      run_sample($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
